addcmp_share_sched: RTL
=======================

Name: addcmp_share_sched

Overview:
- Time-multiplexes one shared add/compare unit across NREQ requesters.
- Unit computes sum = a + b, then flags threshold > sum.
- Round-robin arbitration, registered operand capture, two-cycle issue-to-response latency, valid/ready response port.
- Sits between requester logic and the shared datapath, so we instantiate one adder-comparator instead of NREQ copies.

Parameters:
- NREQ, 3, number of requesters (2..8).
- AW, 2, width of operand a.
- BW, 3, width of operand b.
- SW, 5, width of sum and threshold; must be >= max(AW,BW)+1.
- IDW, 2, width of requester id; must be >= clog2(NREQ).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request; held with operands until its gnt bit is seen.
- a_flat  in  NREQ*AW  operand a, requester i at bits [i*AW +: AW].
- b_flat  in  NREQ*BW  operand b, requester i at bits [i*BW +: BW].
- thr_flat  in  NREQ*SW  threshold, requester i at bits [i*SW +: SW].
- gnt  out  NREQ  one-hot grant, combinational; high only in IDLE, for the cycle its operands are captured.
- busy  out  1  high in EXEC or RESP.
- rsp_valid  out  1  result available.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_sum  out  SW  a + b, zero-extended, unsigned.
- rsp_gt  out  1  1 when thr > sum, unsigned compare.
- rsp_ready  in  1  consumer accepts the result.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (async, any state):
  - state = IDLE; rr_ptr = NREQ-1, so requester 0 has first priority.
  - Operand registers = 0.
  - rsp_valid, rsp_id, rsp_sum, rsp_gt, busy = 0; gnt = 0.
  - Any in-flight operation is discarded; no response is produced for it.
- IDLE:
  - If req != 0, winner = first set bit searching upward from rr_ptr+1, wrapping modulo NREQ.
  - gnt[winner] = 1 this cycle.
  - At the edge: capture a/b/thr of winner and its id; rr_ptr <= winner; go to EXEC.
  - If req == 0: gnt = 0, stay in IDLE.
- EXEC (one cycle):
  - Compute sum = zext(a) + zext(b) into SW bits. Overflow cannot occur given the SW rule.
  - gt = (thr > sum).
  - At the edge: load rsp_sum, rsp_gt, rsp_id; rsp_valid <= 1; go to RESP.
- RESP:
  - rsp_* held stable while rsp_valid && !rsp_ready.
  - On rsp_ready at the edge: rsp_valid <= 0; go to IDLE.
  - rsp_sum, rsp_gt, rsp_id retain their last values after the handshake.
  - No arbitration in this state; gnt = 0.
- Latency and throughput:
  - Grant in cycle T gives rsp_valid from cycle T+2.
  - With rsp_ready tied high, best-case throughput is one operation per 3 cycles.
- Boundary conditions:
  - Requester drops req before being granted: legal, no effect.
  - req asserted during EXEC/RESP: ignored until IDLE.
  - All requesters asserted continuously: grants rotate 0,1,2,0,... with no starvation.
  - Only the last-granted requester asserting: it is re-granted.
  - rsp_ready high outside RESP: ignored.
  - Operand changes after grant: do not affect the in-flight result.

Decomposition:
- Package addcmp_pkg holds:
  - state enum {IDLE, EXEC, RESP};
  - default widths AW/BW/SW/IDW;
  - a function rr_pick(req, ptr) returning the winner index.
- One natural sub-module: addcmp_unit, purely combinational, inputs a/b/thr, outputs sum/gt.
  - Later replaceable by the existing gate-level adder-comparator netlist without changing the scheduler.

Test Plan:
- Reset then req=3'b001, a0=2'd3, b0=3'd5, thr0=5'd9, rsp_ready=1:
  - gnt=001 in cycle T;
  - rsp_valid at T+2 with id=0, sum=8, gt=1;
  - back to IDLE at T+3.
- req=3'b111 held, all thr=0, rsp_ready=1:
  - grant order 0,1,2,0 at 3-cycle spacing;
  - every rsp_gt=0.
- Backpressure: rsp_ready=0 for 5 cycles with a1=1, b1=7, thr1=8:
  - rsp_valid, id=1, sum=8, gt=0 stable for all 5 cycles;
  - no new gnt until 1 cycle after rsp_ready rises.
- Boundary compare, thr=sum exactly (a=2, b=2, thr=4):
  - gt=0;
  - with thr=5, gt=1.
- Assert rst during EXEC:
  - rsp_valid stays 0, busy=0 immediately;
  - after release, req=010 is granted before req0 (ptr reset makes order 0 first only when req0 set; with req=011 the grant is to 0).
- Operands changed the cycle after gnt:
  - result reflects the captured values, not the new ones.

Source files
------------

// File: rtl/addcmp_pkg.sv
// Shared types and helpers for the add/compare sharing scheduler.
// Contents:
//   state_t  - scheduler FSM states (IDLE, EXEC, RESP)
//   DEF_*    - default operand/result/id widths
//   MAXREQ   - largest supported requester count
//   rr_pick  - round-robin winner search starting just after ptr
package addcmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_NREQ = 3;
  localparam int DEF_AW   = 2;
  localparam int DEF_BW   = 3;
  localparam int DEF_SW   = 5;
  localparam int DEF_IDW  = 2;
  localparam int MAXREQ   = 8;

  // Returns the first set bit of req found by walking upward from ptr+1,
  // wrapping at nreq. The loop runs a fixed MAXREQ times so it unrolls to
  // a static priority chain; only the first hit is kept.
  function automatic int rr_pick(input logic [MAXREQ-1:0] req,
                                 input int ptr,
                                 input int nreq);
    int   idx;
    int   win;
    logic found;
    idx   = ptr;
    win   = 0;
    found = 1'b0;
    for (int k = 0; k < MAXREQ; k++) begin
      if (k < nreq) begin
        idx = (idx >= nreq - 1) ? 0 : idx + 1;
        if (!found && req[idx[2:0]]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/addcmp_unit.sv
// Combinational adder-comparator shared by all requesters.
// Kept as its own module so a gate-level netlist can drop in unchanged.
// Ports:
//   a   in  AW  operand a (unsigned)
//   b   in  BW  operand b (unsigned)
//   thr in  SW  threshold (unsigned)
//   sum out SW  zext(a) + zext(b)
//   gt  out 1   thr > sum
module addcmp_unit
  import addcmp_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int BW = DEF_BW,
  parameter int SW = DEF_SW
) (
  input  logic [AW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic [SW-1:0] thr,
  output logic [SW-1:0] sum,
  output logic          gt
);

  // SW >= max(AW,BW)+1, so the sum never overflows.
  assign sum = SW'(a) + SW'(b);
  assign gt  = (thr > sum);

endmodule

// File: rtl/addcmp_share_sched.sv
// Round-robin scheduler time-sharing one addcmp_unit across NREQ requesters.
// A grant in IDLE captures the winner's operands; EXEC runs the unit; RESP
// holds the result on a valid/ready port until it is accepted.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req[NREQ]          per-requester request
//   a_flat/b_flat/thr_flat  packed per-requester operands
//   gnt[NREQ]          one-hot combinational grant (IDLE only)
//   busy               high in EXEC or RESP
//   rsp_valid/rsp_ready  response handshake
//   rsp_id/rsp_sum/rsp_gt  response payload
module addcmp_share_sched
  import addcmp_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW,
  parameter int BW   = DEF_BW,
  parameter int SW   = DEF_SW,
  parameter int IDW  = DEF_IDW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] a_flat,
  input  logic [NREQ*BW-1:0] b_flat,
  input  logic [NREQ*SW-1:0] thr_flat,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [SW-1:0]      rsp_sum,
  output logic               rsp_gt,
  input  logic               rsp_ready
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t         state;
  logic [PW-1:0]  rr_ptr;
  logic [PW-1:0]  sel;
  logic [AW-1:0]  a_reg;
  logic [BW-1:0]  b_reg;
  logic [SW-1:0]  thr_reg;
  logic [IDW-1:0] id_reg;
  logic [SW-1:0]  unit_sum;
  logic           unit_gt;

  logic [AW-1:0] a_arr   [NREQ];
  logic [BW-1:0] b_arr   [NREQ];
  logic [SW-1:0] thr_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi]   = a_flat[gi*AW +: AW];
    assign b_arr[gi]   = b_flat[gi*BW +: BW];
    assign thr_arr[gi] = thr_flat[gi*SW +: SW];
  end

  assign sel  = PW'(rr_pick(MAXREQ'(req), int'(rr_ptr), NREQ));
  assign busy = (state != IDLE);

  always_comb begin
    gnt = '0;
    if (state == IDLE && |req) begin
      gnt[sel] = 1'b1;
    end
  end

  addcmp_unit #(
    .AW(AW),
    .BW(BW),
    .SW(SW)
  ) u_unit (
    .a  (a_reg),
    .b  (b_reg),
    .thr(thr_reg),
    .sum(unit_sum),
    .gt (unit_gt)
  );

  // rr_ptr resets to NREQ-1 so the first search starts at requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= PW'(NREQ - 1);
      a_reg     <= '0;
      b_reg     <= '0;
      thr_reg   <= '0;
      id_reg    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_gt    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            a_reg   <= a_arr[sel];
            b_reg   <= b_arr[sel];
            thr_reg <= thr_arr[sel];
            id_reg  <= IDW'(sel);
            rr_ptr  <= sel;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum   <= unit_sum;
          rsp_gt    <= unit_gt;
          rsp_id    <= id_reg;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          // Payload is left in place after the handshake; only valid drops.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
